// File: rtl/conv_ctrl_pkg.sv
// Shared state encoding and config normalisation for the tiled convolution controller.
package conv_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_LOAD_W  = 4'd1;
  localparam state_t ST_LOAD_B  = 4'd2;
  localparam state_t ST_LOAD_S  = 4'd3;
  localparam state_t ST_LOAD_I  = 4'd4;
  localparam state_t ST_COMPUTE = 4'd5;
  localparam state_t ST_WAIT    = 4'd6;
  localparam state_t ST_OUTPUT  = 4'd7;
  localparam state_t ST_DONE    = 4'd8;

  // A zero count means "one pass"; anything above the hardware limit clamps to it.
  function automatic int cfg_norm(input int val, input int max_val);
    if (val == 0) return 1;
    if (val > max_val) return max_val;
    return val;
  endfunction

endpackage

// File: rtl/conv_tile_ctrl_if.sv
// Host handshake, run configuration and sub-block strobe/status bundle for conv_tile_ctrl.
interface conv_tile_ctrl_if #(
  parameter int OCW = 4,
  parameter int TW  = 6
);
  logic          start;
  logic          abort;
  logic [OCW:0]  cfg_oc_groups;
  logic [TW:0]   cfg_tiles;
  logic          cfg_use_scale;

  logic weight_load_done, bias_load_done, scale_load_done;
  logic input_ready, calc_valid, output_done;

  logic load_weight_en, read_weight_en;
  logic load_bias_en, read_bias_en;
  logic load_scale_en, read_scale_en;
  logic inputbuf_read_en, conv_en, output_en;

  logic [OCW-1:0] oc_idx;
  logic [TW-1:0]  tile_idx;
  logic           busy, done, err;

  modport master (
    input  start, abort, cfg_oc_groups, cfg_tiles, cfg_use_scale,
           weight_load_done, bias_load_done, scale_load_done,
           input_ready, calc_valid, output_done,
    output load_weight_en, read_weight_en, load_bias_en, read_bias_en,
           load_scale_en, read_scale_en, inputbuf_read_en, conv_en, output_en,
           oc_idx, tile_idx, busy, done, err
  );

  modport slave (
    output start, abort, cfg_oc_groups, cfg_tiles, cfg_use_scale,
           weight_load_done, bias_load_done, scale_load_done,
           input_ready, calc_valid, output_done,
    input  load_weight_en, read_weight_en, load_bias_en, read_bias_en,
           load_scale_en, read_scale_en, inputbuf_read_en, conv_en, output_en,
           oc_idx, tile_idx, busy, done, err
  );
endinterface

// File: rtl/conv_tile_counter.sv
// Nested tile/output-channel-group counter; tile is the inner loop, group the outer.
module conv_tile_counter #(
  parameter int OCW = 4,
  parameter int TW  = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           adv,
  input  logic [OCW:0]   groups,
  input  logic [TW:0]    tiles,
  output logic [OCW-1:0] oc_idx,
  output logic [TW-1:0]  tile_idx,
  output logic           last_tile,
  output logic           last_group
);
  localparam logic [OCW:0]   G_ONE   = 1;
  localparam logic [TW:0]    T_ONE   = 1;
  localparam logic [OCW-1:0] OC_INC  = 1;
  localparam logic [TW-1:0]  T_INC   = 1;

  logic [OCW-1:0] oc_q, oc_d;
  logic [TW-1:0]  tile_q, tile_d;
  logic [OCW:0]   groups_m1;
  logic [TW:0]    tiles_m1;

  assign groups_m1  = groups - G_ONE;
  assign tiles_m1   = tiles - T_ONE;
  assign last_group = ({1'b0, oc_q} == groups_m1);
  assign last_tile  = ({1'b0, tile_q} == tiles_m1);
  assign oc_idx     = oc_q;
  assign tile_idx   = tile_q;

  // Group index saturates at the last group so the counters never wrap.
  always_comb begin
    oc_d   = oc_q;
    tile_d = tile_q;
    if (clr) begin
      oc_d   = '0;
      tile_d = '0;
    end else if (adv) begin
      if (last_tile) begin
        tile_d = '0;
        if (!last_group) oc_d = oc_q + OC_INC;
      end else begin
        tile_d = tile_q + T_INC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc_q   <= '0;
      tile_q <= '0;
    end else begin
      oc_q   <= oc_d;
      tile_q <= tile_d;
    end
  end
endmodule

// File: rtl/conv_tile_ctrl.sv
// Tiled 1x1 convolution sequencer: per-group W/B/(S) loads, then per-tile I/compute/wait/output.
// Optional WAIT watchdog enabled by defining CONV_CTRL_WDT_EN.
//
// state     | meaning
// IDLE      | waiting for start, counters cleared
// LOAD_W    | weights loading for current group
// LOAD_B    | bias loading
// LOAD_S    | scale loading (only when cfg_use_scale)
// LOAD_I    | input tile fetch
// COMPUTE   | one-cycle PE array kick
// WAIT      | waiting for calc_valid
// OUTPUT    | writing tile result
// DONE      | one-cycle completion pulse
module conv_tile_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int MAX_OC_GROUPS = 16,
  parameter int MAX_TILES     = 64,
  parameter int OCW           = (MAX_OC_GROUPS > 1) ? $clog2(MAX_OC_GROUPS) : 1,
  parameter int TW            = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1,
  parameter int WDT_CYCLES    = 4096
) (
  input logic              clk,
  input logic              rst_n,
  conv_tile_ctrl_if.master bus
);
  typedef logic [OCW:0] grp_t;
  typedef logic [TW:0]  til_t;

  state_t state_q, state_d;
  grp_t   groups_q, groups_d;
  til_t   tiles_q, tiles_d;
  logic   scale_q, scale_d;
  logic   start_acc, cnt_clr, cnt_adv, last_tile, last_group, wdt_expire;

  assign start_acc = (state_q == ST_IDLE) && bus.start && !bus.abort;

  always_comb begin
    groups_d = groups_q;
    tiles_d  = tiles_q;
    scale_d  = scale_q;
    if (start_acc) begin
      groups_d = grp_t'(cfg_norm(int'(bus.cfg_oc_groups), MAX_OC_GROUPS));
      tiles_d  = til_t'(cfg_norm(int'(bus.cfg_tiles), MAX_TILES));
      scale_d  = bus.cfg_use_scale;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      groups_q <= '0;
      tiles_q  <= '0;
      scale_q  <= 1'b0;
    end else begin
      groups_q <= groups_d;
      tiles_q  <= tiles_d;
      scale_q  <= scale_d;
    end
  end

`ifdef CONV_CTRL_WDT_EN
  localparam int WDTW = $clog2(WDT_CYCLES + 1);
  logic [WDTW-1:0] wdt_q, wdt_d;
  logic            err_q;

  assign wdt_expire = (state_q == ST_WAIT) && !bus.calc_valid &&
                      (wdt_q == WDTW'(WDT_CYCLES - 1));
  assign wdt_d      = (state_q == ST_WAIT) ? wdt_q + WDTW'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_q <= '0;
      err_q <= 1'b0;
    end else begin
      wdt_q <= wdt_d;
      err_q <= wdt_expire && !bus.abort;
    end
  end
  assign bus.err = err_q;
`else
  assign wdt_expire = 1'b0;
  assign bus.err    = 1'b0;
`endif

  // Last tile of the last group is left in place; DONE clears it on the way out.
  assign cnt_adv = (state_q == ST_OUTPUT) && bus.output_done && !(last_tile && last_group);
  assign cnt_clr = bus.abort || wdt_expire || (state_q == ST_DONE);

  conv_tile_counter #(.OCW(OCW), .TW(TW)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (cnt_clr),
    .adv        (cnt_adv),
    .groups     (groups_q),
    .tiles      (tiles_q),
    .oc_idx     (bus.oc_idx),
    .tile_idx   (bus.tile_idx),
    .last_tile  (last_tile),
    .last_group (last_group)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.start) state_d = ST_LOAD_W;
      ST_LOAD_W:  if (bus.weight_load_done) state_d = ST_LOAD_B;
      ST_LOAD_B:  if (bus.bias_load_done) state_d = scale_q ? ST_LOAD_S : ST_LOAD_I;
      ST_LOAD_S:  if (bus.scale_load_done) state_d = ST_LOAD_I;
      ST_LOAD_I:  if (bus.input_ready) state_d = ST_COMPUTE;
      ST_COMPUTE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.calc_valid)  state_d = ST_OUTPUT;
        else if (wdt_expire) state_d = ST_IDLE;
      end
      ST_OUTPUT: begin
        if (bus.output_done) begin
          if (!last_tile)       state_d = ST_LOAD_I;
          else if (!last_group) state_d = ST_LOAD_W;
          else                  state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.abort) state_d = ST_IDLE;
  end

  always_comb begin
    bus.load_weight_en   = (state_q == ST_LOAD_W);
    bus.load_bias_en     = (state_q == ST_LOAD_B);
    bus.load_scale_en    = (state_q == ST_LOAD_S);
    bus.inputbuf_read_en = (state_q == ST_LOAD_I);
    bus.conv_en          = (state_q == ST_COMPUTE);
    bus.output_en        = (state_q == ST_OUTPUT);
    bus.done             = (state_q == ST_DONE);
    bus.busy             = (state_q != ST_IDLE);
    bus.read_weight_en   = bus.load_weight_en && bus.weight_load_done;
    bus.read_bias_en     = bus.load_bias_en && bus.bias_load_done;
    bus.read_scale_en    = bus.load_scale_en && bus.scale_load_done;
  end
endmodule

// File: tb/tb_conv_tile_ctrl.sv
// Self-checking bench for conv_tile_ctrl: status responder, idx scoreboard, per-scenario tasks.
module tb_conv_tile_ctrl;
  localparam int MAXG = 16;
  localparam int MAXT = 64;
  localparam int OCW  = 4;
  localparam int TW   = 6;
  localparam int WDT  = 16;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_tile_ctrl_if #(.OCW(OCW), .TW(TW)) bus ();

  conv_tile_ctrl #(
    .MAX_OC_GROUPS (MAXG),
    .MAX_TILES     (MAXT),
    .WDT_CYCLES    (WDT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  logic [OCW+TW-1:0] exp_q[$];
  int n_lw, n_ls, n_ib, n_ibc, n_conv, n_out, n_done, n_err;
  logic calc_en = 1'b1;
  logic stale_w = 1'b0;

  function automatic logic in_wait();
    return bus.busy && !bus.done &&
           !(bus.load_weight_en || bus.load_bias_en || bus.load_scale_en ||
             bus.inputbuf_read_en || bus.conv_en || bus.output_en);
  endfunction

  // Sub-block model: each status rises LAT cycles into its owning state.
  initial begin : responder
    int cw, cb, cs, ci, cv, co;
    cw = 0; cb = 0; cs = 0; ci = 0; cv = 0; co = 0;
    bus.weight_load_done = 0; bus.bias_load_done = 0; bus.scale_load_done = 0;
    bus.input_ready = 0; bus.calc_valid = 0; bus.output_done = 0;
    forever begin
      @(posedge clk); #1;
      cw = bus.load_weight_en   ? cw + 1 : 0;
      cb = bus.load_bias_en     ? cb + 1 : 0;
      cs = bus.load_scale_en    ? cs + 1 : 0;
      ci = bus.inputbuf_read_en ? ci + 1 : 0;
      co = bus.output_en        ? co + 1 : 0;
      cv = in_wait()            ? cv + 1 : 0;
      bus.weight_load_done = stale_w || (cw >= LAT);
      bus.bias_load_done   = (cb >= LAT);
      bus.scale_load_done  = (cs >= LAT);
      bus.input_ready      = (ci >= LAT);
      bus.calc_valid       = calc_en && (cv >= LAT);
      bus.output_done      = (co >= LAT);
    end
  end

  initial begin : monitor
    logic p_lw, p_ls, p_ib, p_out;
    logic [OCW+TW-1:0] got, e;
    p_lw = 0; p_ls = 0; p_ib = 0; p_out = 0;
    forever begin
      @(negedge clk);
      if (bus.load_weight_en && !p_lw) n_lw++;
      if (bus.load_scale_en && !p_ls) n_ls++;
      if (bus.inputbuf_read_en && !p_ib) n_ib++;
      if (bus.inputbuf_read_en) n_ibc++;
      if (bus.output_en && !p_out) n_out++;
      if (bus.done) n_done++;
      if (bus.err) n_err++;
      if (bus.conv_en) begin
        n_conv++;
        got = {bus.oc_idx, bus.tile_idx};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL idx_seq: conv_en at oc=%0d tile=%0d, no pass expected", bus.oc_idx, bus.tile_idx);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL idx_seq: oc=%0d tile=%0d, expected oc=%0d tile=%0d",
                     got[OCW+TW-1:TW], got[TW-1:0], e[OCW+TW-1:TW], e[TW-1:0]);
          end
        end
      end
      if (bus.load_weight_en || bus.load_bias_en || bus.load_scale_en) begin
        total++;
        if ({bus.read_weight_en, bus.read_bias_en, bus.read_scale_en} !==
            {bus.load_weight_en & bus.weight_load_done, bus.load_bias_en & bus.bias_load_done,
             bus.load_scale_en & bus.scale_load_done}) begin
          bad++;
          $display("FAIL read_en: read w/b/s=%b%b%b, expected %b%b%b",
                   bus.read_weight_en, bus.read_bias_en, bus.read_scale_en,
                   bus.load_weight_en & bus.weight_load_done, bus.load_bias_en & bus.bias_load_done,
                   bus.load_scale_en & bus.scale_load_done);
        end
      end
      p_lw = bus.load_weight_en; p_ls = bus.load_scale_en;
      p_ib = bus.inputbuf_read_en; p_out = bus.output_en;
    end
  end

  task automatic go(input int g, input int t, input logic s, input int eg, input int et,
                    output logic lat_ok);
    n_lw = 0; n_ls = 0; n_ib = 0; n_ibc = 0; n_conv = 0; n_out = 0; n_done = 0; n_err = 0;
    for (int gi = 0; gi < eg; gi++)
      for (int ti = 0; ti < et; ti++)
        exp_q.push_back({OCW'(gi), TW'(ti)});
    @(negedge clk);
    bus.cfg_oc_groups = 5'(g);
    bus.cfg_tiles     = 7'(t);
    bus.cfg_use_scale = s;
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start         = 1'b0;
    bus.cfg_oc_groups = 5'($urandom);
    bus.cfg_tiles     = 7'($urandom);
    bus.cfg_use_scale = ~s;
    lat_ok = (bus.load_weight_en === 1'b1);
  endtask

  task automatic wait_end(output int cyc, output logic od_prev, output logic pulse_ok);
    cyc = 0;
    od_prev = 1'b0;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      od_prev = bus.output_en & bus.output_done;
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    pulse_ok = (bus.done === 1'b0) && (bus.busy === 1'b0);
  endtask

  task automatic test_reset();
    bus.start = 0; bus.abort = 0; bus.cfg_oc_groups = 0; bus.cfg_tiles = 0; bus.cfg_use_scale = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.err, bus.load_weight_en, bus.read_weight_en, bus.load_bias_en,
         bus.read_bias_en, bus.load_scale_en, bus.read_scale_en, bus.inputbuf_read_en,
         bus.conv_en, bus.output_en, bus.oc_idx, bus.tile_idx} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b oc=%0d tile=%0d, all required 0",
               bus.busy, bus.done, bus.err, bus.oc_idx, bus.tile_idx);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_autostart: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_single();
    logic lat_ok, od_prev, pulse_ok;
    int cyc;
    go(1, 1, 1'b1, 1, 1, lat_ok);
    wait_end(cyc, od_prev, pulse_ok);
    total++; if (!lat_ok) begin bad++; $display("FAIL single_start_lat: load_weight_en not 1 cycle after start"); end
    total++; if (cyc >= 3000) begin bad++; $display("FAIL single_timeout: cycles=%0d, done required before 3000", cyc); end
    total++; if (!od_prev) begin bad++; $display("FAIL single_done_lat: output_done not in cycle before done"); end
    total++; if (!pulse_ok) begin bad++; $display("FAIL single_done_pulse: done/busy=%b%b after pulse, required 00", bus.done, bus.busy); end
    total++;
    if ({n_lw, n_ls, n_ib, n_ibc, n_conv, n_out, n_done} !== {32'd1, 32'd1, 32'd1, 32'd2, 32'd1, 32'd1, 32'd1}) begin
      bad++;
      $display("FAIL single_counts: lw=%0d ls=%0d ib=%0d ibc=%0d conv=%0d out=%0d done=%0d, required 1 1 1 2 1 1 1",
               n_lw, n_ls, n_ib, n_ibc, n_conv, n_out, n_done);
    end
  endtask

  task automatic test_multi(input string name, input int g, input int t, input int eg, input int et);
    logic lat_ok, od_prev, pulse_ok;
    int cyc;
    go(g, t, 1'b0, eg, et, lat_ok);
    wait_end(cyc, od_prev, pulse_ok);
    total++; if (!lat_ok) begin bad++; $display("FAIL %s_start_lat: load_weight_en low after start", name); end
    total++; if (!(od_prev && pulse_ok && cyc < 3000)) begin
      bad++; $display("FAIL %s_end: od_prev=%b pulse_ok=%b cycles=%0d, required 1 1 <3000", name, od_prev, pulse_ok, cyc);
    end
    total++;
    if ({n_lw, n_ls, n_ib, n_conv, n_out, n_done, 32'(exp_q.size())} !==
        {32'(eg), 32'd0, 32'(eg*et), 32'(eg*et), 32'(eg*et), 32'd1, 32'd0}) begin
      bad++;
      $display("FAIL %s_counts: lw=%0d ls=%0d ib=%0d conv=%0d out=%0d done=%0d left=%0d, required %0d 0 %0d %0d %0d 1 0",
               name, n_lw, n_ls, n_ib, n_conv, n_out, n_done, exp_q.size(), eg, eg*et, eg*et, eg*et);
    end
  endtask

  task automatic test_abort();
    logic lat_ok, od_prev, pulse_ok, found;
    int cyc;
    go(2, 3, 1'b0, 2, 3, lat_ok);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (in_wait() && bus.oc_idx == 1 && bus.tile_idx == 2) found = 1'b1;
      else @(negedge clk);
    end
    total++; if (!found) begin bad++; $display("FAIL abort_reach_wait: WAIT of group 1 tile 2 not reached"); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    total++;
    if ({bus.busy, bus.oc_idx, bus.tile_idx} !== '0) begin
      bad++; $display("FAIL abort_idle: busy=%b oc=%0d tile=%0d, required 0 0 0", bus.busy, bus.oc_idx, bus.tile_idx);
    end
    repeat (5) @(negedge clk);
    total++;
    if ({n_done, n_conv, 32'(exp_q.size())} !== {32'd0, 32'd6, 32'd0}) begin
      bad++; $display("FAIL abort_no_done: done=%0d conv=%0d left=%0d, required 0 6 0", n_done, n_conv, exp_q.size());
    end
    bus.abort = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0; bus.start = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_start_idle: busy=%b, required 0", bus.busy); end
    go(1, 2, 1'b0, 1, 2, lat_ok);
    wait_end(cyc, od_prev, pulse_ok);
    total++;
    if (!(lat_ok && pulse_ok) || {n_lw, n_conv, n_done} !== {32'd1, 32'd2, 32'd1}) begin
      bad++; $display("FAIL abort_rerun: lat=%b pulse=%b lw=%0d conv=%0d done=%0d, required 1 1 1 2 1",
                      lat_ok, pulse_ok, n_lw, n_conv, n_done);
    end
  endtask

  task automatic test_stale_start();
    logic lat_ok, od_prev, pulse_ok;
    int cyc, guard;
    go(1, 2, 1'b0, 1, 2, lat_ok);
    guard = 0;
    while (!bus.load_bias_en && guard < 100) begin @(negedge clk); guard++; end
    stale_w = 1'b1;
    while (!bus.inputbuf_read_en && guard < 200) begin @(negedge clk); guard++; end
    bus.start = 1'b1; bus.cfg_tiles = 7'd5; bus.cfg_oc_groups = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.output_en && guard < 300) begin @(negedge clk); guard++; end
    stale_w = 1'b0;
    wait_end(cyc, od_prev, pulse_ok);
    total++; if (guard >= 300) begin bad++; $display("FAIL stale_progress: guard=%0d, required <300", guard); end
    total++;
    if ({n_lw, n_ib, n_ibc, n_conv, n_out, n_done, 32'(exp_q.size())} !==
        {32'd1, 32'd2, 32'd4, 32'd2, 32'd2, 32'd1, 32'd0}) begin
      bad++;
      $display("FAIL stale_counts: lw=%0d ib=%0d ibc=%0d conv=%0d out=%0d done=%0d left=%0d, required 1 2 4 2 2 1 0",
               n_lw, n_ib, n_ibc, n_conv, n_out, n_done, exp_q.size());
    end
    total++; if (!pulse_ok) begin bad++; $display("FAIL stale_end: busy=%b after done, required 0", bus.busy); end
  endtask

  task automatic test_midrun_reset();
    logic lat_ok;
    go(2, 3, 1'b1, 2, 3, lat_ok);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.oc_idx, bus.tile_idx, bus.load_weight_en, bus.conv_en} !== '0) begin
      bad++; $display("FAIL async_reset: busy=%b oc=%0d tile=%0d, required all 0", bus.busy, bus.oc_idx, bus.tile_idx);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wdt();
    logic lat_ok, found;
    int c;
    calc_en = 1'b0;
    go(1, 1, 1'b0, 1, 1, lat_ok);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (in_wait()) found = 1'b1;
      else @(negedge clk);
    end
    total++; if (!found) begin bad++; $display("FAIL wdt_reach_wait: WAIT not reached"); end
    c = 0;
`ifdef CONV_CTRL_WDT_EN
    while (bus.err !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    total++; if (c != WDT) begin bad++; $display("FAIL wdt_err_time: err after %0d cycles, required %0d", c, WDT); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL wdt_idle: busy=%b, required 0", bus.busy); end
    @(negedge clk);
    total++;
    if ({bus.err, 32'(n_done), 32'(n_err)} !== {1'b0, 32'd0, 32'd1}) begin
      bad++; $display("FAIL wdt_pulse: err=%b done=%0d errs=%0d, required 0 0 1", bus.err, n_done, n_err);
    end
`else
    repeat (40) begin @(negedge clk); c++; end
    total++;
    if ({in_wait(), bus.err, 32'(n_err), 32'(n_done)} !== {1'b1, 1'b0, 32'd0, 32'd0}) begin
      bad++; $display("FAIL wdt_off_hold: wait=%b err=%b errs=%0d done=%0d, required 1 0 0 0",
                      in_wait(), bus.err, n_err, n_done);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL wdt_off_abort: busy=%b, required 0", bus.busy); end
`endif
    calc_en = 1'b1;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    test_reset();
    test_single();
    test_multi("g2t3", 2, 3, 2, 3);
    test_multi("zero_cfg", 0, 0, 1, 1);
    test_multi("sat_tiles", 1, MAXT + 5, 1, MAXT);
    test_multi("sat_groups", 20, 1, MAXG, 1);
    test_abort();
    test_stale_start();
    test_midrun_reset();
    test_multi("after_reset", 1, 2, 1, 2);
    test_wdt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_tile_ctrl.md
Name: conv_tile_ctrl

Overview:
- Parametrised successor to the fixed single-pass 1x1 convolution controller.
- Sequences weight, bias and optional scale loads once per output-channel group. For each group it then loops input load, compute, wait and output over a configurable number of spatial tiles.
- Runs are started by an explicit start/busy/done handshake with abort; the block never auto-restarts.
- Sits between the host/top-level scheduler and the weight, bias, scale, input-buffer, PE-array and output-writer sub-blocks.

Parameters:
- MAX_OC_GROUPS, 16: maximum output-channel groups per run.
- MAX_TILES, 64: maximum spatial tiles per group.
- OCW, $clog2(MAX_OC_GROUPS) (min 1): oc_idx width.
- TW, $clog2(MAX_TILES) (min 1): tile_idx width.
- WDT_CYCLES, 4096: WAIT-state timeout; used only with CONV_CTRL_WDT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle run request; honoured only in IDLE.
- abort  in  1  synchronous abort, honoured in any state.
- cfg_oc_groups  in  OCW+1  group count; 0 treated as 1.
- cfg_tiles  in  TW+1  tiles per group; 0 treated as 1.
- cfg_use_scale  in  1  1 = run LOAD_S; 0 = skip it.
- weight_load_done, bias_load_done, scale_load_done, input_ready, calc_valid, output_done  in  1 each  sub-block status.
- load_weight_en, read_weight_en, load_bias_en, read_bias_en, load_scale_en, read_scale_en  out  1 each  load strobes.
- inputbuf_read_en, conv_en, output_en  out  1 each  datapath strobes.
- oc_idx  out  OCW  current group.
- tile_idx  out  TW  current tile.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, run finished.
- err  out  1  one-cycle pulse on watchdog timeout.

Behaviour:
- Reset: state=IDLE, counters 0, cfg registers 0. All outputs 0.
- Config capture: cfg_* are registered when start is accepted in IDLE. Values above the MAX_* parameters saturate to the MAX.
- State flow:
  - IDLE -> LOAD_W on start.
  - LOAD_W -> LOAD_B on weight_load_done.
  - LOAD_B -> (cfg_use_scale ? LOAD_S : LOAD_I) on bias_load_done.
  - LOAD_S -> LOAD_I on scale_load_done.
  - LOAD_I -> COMPUTE on input_ready.
  - COMPUTE -> WAIT unconditionally (1 cycle).
  - WAIT -> OUTPUT on calc_valid.
  - OUTPUT exits on output_done, see loop rules below.
  - DONE -> IDLE unconditionally (1 cycle).
- Loop rules on OUTPUT & output_done:
  - tile_idx < tiles-1: tile_idx++, go LOAD_I (no weight reload).
  - else if oc_idx < groups-1: oc_idx++, tile_idx=0, go LOAD_W.
  - else go DONE.
- Output decode (Moore, combinational from state):
  - load_X_en=1 throughout LOAD_X.
  - read_X_en = load_X_en & X_load_done.
  - inputbuf_read_en=1 in LOAD_I.
  - conv_en=1 in COMPUTE.
  - output_en=1 in OUTPUT.
  - done=1 in DONE.
- Latency: start to load_weight_en = 1 cycle. Final output_done to done = 1 cycle.
- Status inputs are ignored outside their owning state; a stale done never skips a state.
- Priority: abort > everything. Abort moves to IDLE next cycle, clears counters and produces no done pulse. Abort and start together in IDLE: stay IDLE.
- start while busy: ignored; config is not re-sampled.
- Boundaries: 1x1 config (groups=1, tiles=1) degenerates to the legacy single pass. Counters never wrap past the configured limit.
- rst_n assertion mid-run returns to reset values immediately (asynchronous).

Optional Feature:
- Macro CONV_CTRL_WDT_EN.
- Defined: a cycle counter runs in WAIT, cleared on entry. If it reaches WDT_CYCLES without calc_valid, the FSM goes to IDLE, pulses err for 1 cycle, clears counters and does not pulse done.
- Not defined: WAIT holds indefinitely; err is tied 0 and no counter logic is generated.

Decomposition:
- conv_ctrl_pkg: state encoding localparams (IDLE..DONE, 4-bit) and the shared saturate/zero-as-one config helper function.
- One natural sub-module, conv_tile_counter: a nested two-level (tile, oc) counter with clear, advance and last_tile/last_group flags. The FSM consumes these flags.

Test Plan:
- groups=1, tiles=1, use_scale=1, every done returned 2 cycles after its enable -> exactly one W/B/S/I/COMPUTE/OUTPUT sequence, done pulse 1 cycle, busy low afterwards.
- groups=2, tiles=3, use_scale=0 -> load_weight_en asserted 2 times, inputbuf_read_en episodes 6, conv_en pulses 6, load_scale_en never; idx sequence (0,0)(0,1)(0,2)(1,0)(1,1)(1,2).
- cfg_tiles=0, cfg_oc_groups=0 -> behaves as 1/1. cfg_tiles=MAX_TILES+5 -> exactly MAX_TILES tiles.
- abort asserted in WAIT of group 1 tile 2 -> IDLE next cycle, idx=0, no done. A following start runs cleanly from group 0.
- start pulsed during LOAD_I, and weight_load_done held high throughout LOAD_I -> no restart, no state skip.
- CONV_CTRL_WDT_EN, WDT_CYCLES=16, calc_valid never asserted -> err pulse exactly 16 cycles after WAIT entry, then IDLE. Without the macro, remains in WAIT with err=0.
